// File: rtl/timer_bank.sv
// Bank of independent countdown timers on a shared game-rate tick; expiry pulse one clk after the terminal tick edge.
// No backpressure: start/cancel/pause/tick act on the edge that samples them; all outputs come from registers.
module timer_bank #(
    parameter int N_CH         = 4,
    parameter int WIDTH        = 8,
    parameter int DEFAULT_LOAD = 120
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic [N_CH-1:0]         start,
    input  logic [N_CH*WIDTH-1:0]   load_val,
    input  logic [N_CH-1:0]         reload_mode,
    input  logic [N_CH-1:0]         pause,
    input  logic [N_CH-1:0]         cancel,
    output logic [N_CH*WIDTH-1:0]   count,
    output logic [N_CH-1:0]         running,
    output logic [N_CH-1:0]         timer_up,
    output logic [N_CH-1:0]         expired
);

    if (DEFAULT_LOAD < 0 || (DEFAULT_LOAD >> WIDTH) != 0) begin : g_bad_default
        $error("timer_bank: DEFAULT_LOAD does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] DEF_LOAD = WIDTH'(DEFAULT_LOAD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state_q  [N_CH];
    state_t           state_d  [N_CH];
    logic [WIDTH-1:0] count_q  [N_CH];
    logic [WIDTH-1:0] count_d  [N_CH];
    logic [WIDTH-1:0] reload_q [N_CH];
    logic [WIDTH-1:0] reload_d [N_CH];
    logic [N_CH-1:0]  mode_q;
    logic [N_CH-1:0]  mode_d;
    logic [N_CH-1:0]  expired_q;
    logic [N_CH-1:0]  expired_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= ST_IDLE;
                count_q[i]  <= '0;
                reload_q[i] <= '0;
            end
            mode_q    <= '0;
            expired_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= state_d[i];
                count_q[i]  <= count_d[i];
                reload_q[i] <= reload_d[i];
            end
            mode_q    <= mode_d;
            expired_q <= expired_d;
        end
    end

    // Priority per channel: cancel, start, pause, tick.
    always_comb begin
        logic [WIDTH-1:0] eff;
        eff       = '0;
        mode_d    = mode_q;
        expired_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i]  = state_q[i];
            count_d[i]  = count_q[i];
            reload_d[i] = reload_q[i];
            eff         = load_val[i*WIDTH +: WIDTH];
            if (eff == '0) begin
                eff = DEF_LOAD;
            end

            if (cancel[i]) begin
                state_d[i] = ST_IDLE;
                count_d[i] = '0;
            end else if (start[i]) begin
                state_d[i]  = ST_RUN;
                count_d[i]  = eff;
                reload_d[i] = eff;
                mode_d[i]   = reload_mode[i];
            end else begin
                unique case (state_q[i])
                    ST_RUN: begin
                        if (pause[i]) begin
                            // The tick on the first paused cycle is dropped as well.
                            state_d[i] = ST_HOLD;
                        end else if (tick && count_q[i] != '0) begin
                            if (count_q[i] == WIDTH'(1)) begin
                                expired_d[i] = 1'b1;
                                if (mode_q[i]) begin
                                    count_d[i] = reload_q[i];
                                end else begin
                                    count_d[i] = '0;
                                    state_d[i] = ST_IDLE;
                                end
                            end else begin
                                count_d[i] = count_q[i] - WIDTH'(1);
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (!pause[i]) begin
                            state_d[i] = ST_RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_out
        assign count[g*WIDTH +: WIDTH] = count_q[g];
        assign running[g]              = (state_q[g] == ST_RUN);
        assign timer_up[g]             = (state_q[g] == ST_IDLE);
    end

    assign expired = expired_q;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: one task per scenario with hand-computed expectations.
module tb_timer_bank;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           tick;
    logic [N-1:0]   start;
    logic [N*W-1:0] load_val;
    logic [N-1:0]   reload_mode;
    logic [N-1:0]   pause;
    logic [N-1:0]   cancel;
    logic [N*W-1:0] count;
    logic [N-1:0]   running;
    logic [N-1:0]   timer_up;
    logic [N-1:0]   expired;

    int n_cmp = 0;
    int n_bad = 0;

    timer_bank #(.N_CH(N), .WIDTH(W), .DEFAULT_LOAD(120)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .start       (start),
        .load_val    (load_val),
        .reload_mode (reload_mode),
        .pause       (pause),
        .cancel      (cancel),
        .count       (count),
        .running     (running),
        .timer_up    (timer_up),
        .expired     (expired)
    );

    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] cnt(input int ch);
        return count[ch*W +: W];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic start_ch(input int ch, input logic [W-1:0] lv, input logic rm);
        load_val[ch*W +: W] = lv;
        reload_mode[ch]     = rm;
        start[ch]           = 1'b1;
        cyc();
        start[ch]           = 1'b0;
    endtask

    task automatic test_reset();
        logic any_exp;
        logic [N*W-1:0] cnt_snap;
        #2;
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL reset_count: got %h required 0", count); end
        n_cmp++; if (timer_up !== 4'hF) begin n_bad++; $display("FAIL reset_timer_up: got %b required 1111", timer_up); end
        n_cmp++; if (running !== 4'h0) begin n_bad++; $display("FAIL reset_running: got %b required 0000", running); end
        n_cmp++; if (expired !== 4'h0) begin n_bad++; $display("FAIL reset_expired: got %b required 0000", expired); end
        cyc();
        rst_n = 1'b1;
        cyc();
        any_exp = 1'b0;
        for (int k = 0; k < 200; k++) begin
            do_tick();
            any_exp |= |expired;
            cyc();
        end
        cnt_snap = count;
        n_cmp++; if (cnt_snap !== '0) begin n_bad++; $display("FAIL idle_ticks_count: got %h required 0", cnt_snap); end
        n_cmp++; if (any_exp !== 1'b0) begin n_bad++; $display("FAIL idle_ticks_expired: got %b required 0", any_exp); end
        n_cmp++; if (timer_up !== 4'hF) begin n_bad++; $display("FAIL idle_ticks_timer_up: got %b required 1111", timer_up); end
    endtask

    task automatic test_oneshot();
        logic any_exp;
        start_ch(0, 8'd0, 1'b0);
        n_cmp++; if (cnt(0) !== 8'd120) begin n_bad++; $display("FAIL oneshot_default_load: got %0d required 120", cnt(0)); end
        n_cmp++; if (running[0] !== 1'b1 || timer_up[0] !== 1'b0) begin n_bad++; $display("FAIL oneshot_running: got run=%b up=%b required run=1 up=0", running[0], timer_up[0]); end
        any_exp = 1'b0;
        for (int k = 0; k < 119; k++) begin
            do_tick();
            any_exp |= expired[0];
            cyc();
        end
        n_cmp++; if (cnt(0) !== 8'd1) begin n_bad++; $display("FAIL oneshot_119_ticks: got %0d required 1", cnt(0)); end
        n_cmp++; if (any_exp !== 1'b0) begin n_bad++; $display("FAIL oneshot_early_expiry: got %b required 0", any_exp); end
        do_tick();
        n_cmp++; if (expired[0] !== 1'b1) begin n_bad++; $display("FAIL oneshot_expired_pulse: got %b required 1", expired[0]); end
        n_cmp++; if (cnt(0) !== 8'd0 || timer_up[0] !== 1'b1) begin n_bad++; $display("FAIL oneshot_terminal: got count=%0d up=%b required count=0 up=1", cnt(0), timer_up[0]); end
        cyc();
        n_cmp++; if (expired[0] !== 1'b0) begin n_bad++; $display("FAIL oneshot_pulse_width: got %b required 0", expired[0]); end
        any_exp = 1'b0;
        for (int k = 0; k < 5; k++) begin
            do_tick();
            any_exp |= expired[0];
        end
        n_cmp++; if (cnt(0) !== 8'd0 || any_exp !== 1'b0) begin n_bad++; $display("FAIL oneshot_after: got count=%0d exp=%b required count=0 exp=0", cnt(0), any_exp); end
    endtask

    task automatic test_reload();
        logic [W-1:0] exp_cnt;
        start_ch(1, 8'd3, 1'b1);
        reload_mode[1] = 1'b0;
        n_cmp++; if (cnt(1) !== 8'd3) begin n_bad++; $display("FAIL reload_load: got %0d required 3", cnt(1)); end
        for (int k = 1; k <= 9; k++) begin
            exp_cnt = (k % 3 == 0) ? 8'd3 : W'(3 - (k % 3));
            do_tick();
            n_cmp++; if (cnt(1) !== exp_cnt) begin n_bad++; $display("FAIL reload_count_tick%0d: got %0d required %0d", k, cnt(1), exp_cnt); end
            n_cmp++; if (expired[1] !== (k % 3 == 0)) begin n_bad++; $display("FAIL reload_expired_tick%0d: got %b required %b", k, expired[1], (k % 3 == 0)); end
            n_cmp++; if (running[1] !== 1'b1) begin n_bad++; $display("FAIL reload_running_tick%0d: got %b required 1", k, running[1]); end
            cyc();
            n_cmp++; if (expired[1] !== 1'b0) begin n_bad++; $display("FAIL reload_pulse_width_tick%0d: got %b required 0", k, expired[1]); end
            cyc();
            cyc();
        end
        cancel[1] = 1'b1;
        cyc();
        cancel[1] = 1'b0;
        n_cmp++; if (cnt(1) !== 8'd0 || timer_up[1] !== 1'b1 || expired[1] !== 1'b0) begin n_bad++; $display("FAIL reload_cancel: got count=%0d up=%b exp=%b required 0/1/0", cnt(1), timer_up[1], expired[1]); end
    endtask

    task automatic test_pause();
        start_ch(2, 8'd5, 1'b0);
        do_tick();
        do_tick();
        n_cmp++; if (cnt(2) !== 8'd3) begin n_bad++; $display("FAIL pause_pre: got %0d required 3", cnt(2)); end
        pause[2] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            do_tick();
            cyc();
        end
        n_cmp++; if (cnt(2) !== 8'd3) begin n_bad++; $display("FAIL pause_hold_count: got %0d required 3", cnt(2)); end
        n_cmp++; if (running[2] !== 1'b0 || timer_up[2] !== 1'b0) begin n_bad++; $display("FAIL pause_hold_state: got run=%b up=%b required 0/0", running[2], timer_up[2]); end
        pause[2] = 1'b0;
        cyc();
        n_cmp++; if (running[2] !== 1'b1) begin n_bad++; $display("FAIL pause_release: got %b required 1", running[2]); end
        do_tick();
        do_tick();
        n_cmp++; if (cnt(2) !== 8'd1 || expired[2] !== 1'b0) begin n_bad++; $display("FAIL pause_resume: got count=%0d exp=%b required 1/0", cnt(2), expired[2]); end
        do_tick();
        n_cmp++; if (expired[2] !== 1'b1 || timer_up[2] !== 1'b1) begin n_bad++; $display("FAIL pause_expiry: got exp=%b up=%b required 1/1", expired[2], timer_up[2]); end
        pause[2] = 1'b1;
        cyc();
        pause[2] = 1'b0;
        n_cmp++; if (timer_up[2] !== 1'b1 || running[2] !== 1'b0) begin n_bad++; $display("FAIL pause_in_idle: got up=%b run=%b required 1/0", timer_up[2], running[2]); end
    endtask

    task automatic test_collisions();
        start_ch(0, 8'd7, 1'b0);
        load_val[0 +: W] = 8'd9;
        start[0]  = 1'b1;
        cancel[0] = 1'b1;
        cyc();
        start[0]  = 1'b0;
        cancel[0] = 1'b0;
        n_cmp++; if (cnt(0) !== 8'd0 || timer_up[0] !== 1'b1) begin n_bad++; $display("FAIL cancel_with_start: got count=%0d up=%b required 0/1", cnt(0), timer_up[0]); end
        start_ch(0, 8'd2, 1'b0);
        do_tick();
        tick      = 1'b1;
        cancel[0] = 1'b1;
        cyc();
        tick      = 1'b0;
        cancel[0] = 1'b0;
        n_cmp++; if (expired[0] !== 1'b0 || cnt(0) !== 8'd0 || timer_up[0] !== 1'b1) begin n_bad++; $display("FAIL cancel_on_terminal: got exp=%b count=%0d up=%b required 0/0/1", expired[0], cnt(0), timer_up[0]); end
        cyc();
        n_cmp++; if (expired[0] !== 1'b0) begin n_bad++; $display("FAIL cancel_on_terminal_late: got %b required 0", expired[0]); end
        load_val[0 +: W] = 8'd4;
        start[0] = 1'b1;
        tick     = 1'b1;
        cyc();
        start[0] = 1'b0;
        tick     = 1'b0;
        n_cmp++; if (cnt(0) !== 8'd4) begin n_bad++; $display("FAIL start_on_tick: got %0d required 4", cnt(0)); end
        do_tick();
        do_tick();
        n_cmp++; if (cnt(0) !== 8'd2) begin n_bad++; $display("FAIL restart_pre: got %0d required 2", cnt(0)); end
        start_ch(0, 8'd10, 1'b0);
        n_cmp++; if (cnt(0) !== 8'd10 || expired[0] !== 1'b0 || running[0] !== 1'b1) begin n_bad++; $display("FAIL restart: got count=%0d exp=%b run=%b required 10/0/1", cnt(0), expired[0], running[0]); end
        start_ch(0, 8'd1, 1'b0);
        do_tick();
        n_cmp++; if (expired[0] !== 1'b1 || cnt(0) !== 8'd0) begin n_bad++; $display("FAIL load_one_latency: got exp=%b count=%0d required 1/0", expired[0], cnt(0)); end
    endtask

    task automatic test_async_reset();
        start_ch(3, 8'd50, 1'b0);
        n_cmp++; if (cnt(3) !== 8'd50) begin n_bad++; $display("FAIL areset_pre: got %0d required 50", cnt(3)); end
        do_tick();
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (count !== '0 || timer_up !== 4'hF || running !== 4'h0 || expired !== 4'h0) begin n_bad++; $display("FAIL areset_immediate: got count=%h up=%b run=%b exp=%b required 0/1111/0000/0000", count, timer_up, running, expired); end
        cyc();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            do_tick();
        end
        n_cmp++; if (cnt(3) !== 8'd0 || timer_up[3] !== 1'b1 || expired[3] !== 1'b0) begin n_bad++; $display("FAIL areset_stays_idle: got count=%0d up=%b exp=%b required 0/1/0", cnt(3), timer_up[3], expired[3]); end
        start_ch(3, 8'd0, 1'b0);
        n_cmp++; if (cnt(3) !== 8'd120 || running[3] !== 1'b1) begin n_bad++; $display("FAIL areset_restart: got count=%0d run=%b required 120/1", cnt(3), running[3]); end
    endtask

    initial begin
        rst_n       = 1'b0;
        tick        = 1'b0;
        start       = '0;
        load_val    = '0;
        reload_mode = '0;
        pause       = '0;
        cancel      = '0;
        test_reset();
        test_oneshot();
        test_reload();
        test_pause();
        test_collisions();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Parametrised multi-channel countdown timer bank. Successor to the single 2-second new-ball timer.
- Each channel counts down a loadable value on a shared game-rate tick (60 Hz enable).
- Each channel supports one-shot or auto-reload mode, pause/hold, cancel, and a one-cycle expiry pulse.
- Used by the game FSM for new-ball delay, serve countdown, power-up duration and blink timing.

Parameters:
- N_CH, 4, number of independent timer channels.
- WIDTH, 8, counter width per channel in bits.
- DEFAULT_LOAD, 120, value loaded when start is asserted with load_val==0. 120 ticks = 2 s at 60 Hz. Must be < 2^WIDTH.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  shared count-enable strobe, one clk wide (60 Hz).
- start  input  N_CH  per-channel start/restart strobe.
- load_val  input  N_CH*WIDTH  per-channel load value; channel i uses bits [i*WIDTH +: WIDTH].
- reload_mode  input  N_CH  1 = auto-reload on expiry, 0 = one-shot. Sampled at start.
- pause  input  N_CH  level; 1 holds the channel's count.
- cancel  input  N_CH  strobe; abort the channel with no expiry pulse.
- count  output  N_CH*WIDTH  current count per channel.
- running  output  N_CH  1 when the channel is in RUN.
- timer_up  output  N_CH  level; 1 when the channel is in IDLE.
- expired  output  N_CH  one-clk pulse when the count reaches terminal.

Behaviour:
- Reset (async, rst_n=0), per channel:
  - state=IDLE, count=0, reload register=0, mode register=0.
  - expired=0, running=0, timer_up=1.
  - Reset mid-count aborts immediately; no expired pulse is generated.
- Per-channel state machine, states IDLE, RUN, HOLD:
  - IDLE: start -> RUN.
  - RUN: pause=1 -> HOLD; expiry in one-shot mode -> IDLE; expiry in reload mode stays in RUN.
  - HOLD: pause=0 -> RUN.
  - Any state: cancel -> IDLE with count=0.
  - Any state: start -> RUN, unless cancel is also asserted.
- Priority per channel, highest first: reset, cancel, start, pause, tick.
- Start:
  - eff = (load_val==0) ? DEFAULT_LOAD : load_val.
  - On the start edge: count<=eff, reload register<=eff, mode register<=reload_mode, state<=RUN.
  - A tick coincident with start is ignored.
  - Start while in RUN or HOLD restarts the channel with no expired pulse.
- Counting:
  - Counting happens only in RUN, with tick=1, pause=0 and no start or cancel that cycle.
  - count>1: count<=count-1.
  - count==1 (terminal tick), one-shot: count<=0, state<=IDLE, expired=1 for exactly one clk.
  - count==1 (terminal tick), reload: count<=reload register, stays in RUN, expired=1 for one clk.
  - count never wraps below 0.
- Latency:
  - After start with eff=L, expired is high in the cycle following the edge that samples the L-th qualifying tick.
  - count reads 0 and timer_up=1 in that same cycle (one-shot).
- Pause:
  - A tick on a cycle with pause=1 is dropped, including the first pause cycle.
  - pause in IDLE has no effect.
- Cancel:
  - In IDLE, cancel is a no-op.
  - Cancel on the same cycle as the terminal tick wins: no expired pulse.
- Outputs:
  - All outputs are registered or decoded directly from state/count, with no combinational path from inputs.
  - running = (state==RUN). timer_up = (state==IDLE).
- Channels are fully independent; only tick is shared.
- Width: load_val is taken as-is. DEFAULT_LOAD is truncated to WIDTH, and implementation flags an elaboration error if it is out of range.

Test Plan:
- Reset then idle: all count=0, timer_up=all 1, running=0, expired=0. 200 ticks with no start -> unchanged.
- Ch0 one-shot: start with load_val=0 -> count=120. After 119 ticks count=1. The 120th tick -> count=0, expired[0] high for 1 clk, timer_up[0]=1. Further ticks do nothing.
- Ch1 reload: start with load_val=3, reload_mode=1; tick every 4 clk. expired[1] pulses on ticks 3, 6 and 9; count sequence 3,2,1,3,2,1,3; running[1] stays 1.
- Pause: ch2 started at 5; 2 ticks -> count 3. pause=1 for 10 ticks -> count stays 3 and state is HOLD. Release, then 3 ticks -> expired[2] pulses.
- Collisions:
  - cancel with start together -> IDLE, count=0.
  - cancel on the terminal tick -> no pulse.
  - start on a tick cycle -> count=load, tick ignored.
  - restart at count=2 with 10 -> count=10, no pulse.
- Async reset asserted mid-count (ch3 at 50) between clock edges -> outputs at reset values immediately. After release, the channel stays IDLE until start.
